// File: rtl/proc_token_sched.sv
// proc_token_sched: round-robin token scheduler for cooperating processes.
// Pending wake bits are latched per process; one winner at a time is granted.
// Ports in : clk, rst_n, start, ext_wake, delay_cfg, done,
//            wake_tgt_vld, wake_tgt
// Ports out: grant, grant_id, busy, finish, stall, wake_ovf, act_cnt
module proc_token_sched #(
    parameter int NPROC   = 3,
    parameter int DLY_W   = 4,
    parameter int MAX_ACT = 6,
    parameter int CNT_W   = 8,
    parameter int IDW     = $clog2(NPROC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NPROC-1:0] ext_wake,
    input  logic [DLY_W-1:0] delay_cfg,
    input  logic             done,
    input  logic             wake_tgt_vld,
    input  logic [IDW-1:0]   wake_tgt,
    output logic [NPROC-1:0] grant,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic             finish,
    output logic             stall,
    output logic             wake_ovf,
    output logic [CNT_W-1:0] act_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_DELAY,
        S_RUN,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [NPROC-1:0] r_pending;
    logic [NPROC-1:0] r_grant;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic [DLY_W-1:0] r_dcnt;
    logic             r_busy;
    logic             r_finish;
    logic             r_stall;
    logic             r_wake_ovf;
    logic [CNT_W-1:0] r_act_cnt;

    logic             w_active;
    logic             w_done_fire;
    logic             w_tgt_bad;
    logic             w_dup;
    logic [NPROC-1:0] w_ext;
    logic [NPROC-1:0] w_done_wake;
    logic [NPROC-1:0] w_wake;

    logic             w_hi_found;
    logic             w_lo_found;
    logic             w_found;
    logic [IDW-1:0]   w_hi_win;
    logic [IDW-1:0]   w_lo_win;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_rr_next;
    logic [NPROC-1:0] w_win_oh;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;

    function automatic logic [NPROC-1:0] f_onehot(
        input logic [IDW-1:0] id
    );
        logic [NPROC-1:0] v;
        v = '0;
        for (int i = 0; i < NPROC; i++) begin
            if (int'(id) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Wake sources: external pulses and the wake carried by done.
    // Both are ignored while the scheduler is idle or finished.
    always_comb begin
        w_active    = (r_state != S_IDLE) && (r_state != S_FINISH);
        w_done_fire = (r_state == S_RUN) && done;
        w_ext       = w_active ? ext_wake : '0;
        w_done_wake = '0;
        w_tgt_bad   = 1'b0;
        if (w_done_fire && wake_tgt_vld) begin
            if (int'(wake_tgt) < NPROC) begin
                w_done_wake = f_onehot(wake_tgt);
            end else begin
                w_tgt_bad = 1'b1;
            end
        end
        w_wake = w_ext | w_done_wake;
        // A wake is lost if its bit is already pending or both
        // sources hit the same bit in one cycle.
        w_dup  = (|(w_wake & r_pending)) ||
                 (|(w_ext & w_done_wake));
    end

    // Round-robin search: lowest pending index at or above rr_ptr,
    // otherwise lowest pending index below it (wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_win   = '0;
        w_lo_win   = '0;
        for (int j = NPROC - 1; j >= 0; j--) begin
            if (r_pending[j]) begin
                if (j >= int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_win   = IDW'(j);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_win   = IDW'(j);
                end
            end
        end
        w_found   = w_hi_found | w_lo_found;
        w_win     = w_hi_found ? w_hi_win : w_lo_win;
        w_win_oh  = w_found ? f_onehot(w_win) : '0;
        w_rr_next = (int'(w_win) == NPROC - 1) ?
                    '0 : w_win + IDW'(1);
        w_cnt_inc = (r_act_cnt >= CNT_W'(MAX_ACT)) ?
                    r_act_cnt : r_act_cnt + CNT_W'(1);
        w_last    = (w_cnt_inc == CNT_W'(MAX_ACT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_dcnt     <= '0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_stall    <= 1'b0;
            r_wake_ovf <= 1'b0;
            r_act_cnt  <= '0;
        end else begin
            if (w_active) begin
                r_pending <= r_pending | w_wake;
            end
            if (w_dup || w_tgt_bad) begin
                r_wake_ovf <= 1'b1;
            end
            unique case (r_state)
                S_IDLE, S_FINISH: begin
                    if (start) begin
                        r_pending  <= NPROC'(1);
                        r_act_cnt  <= '0;
                        r_stall    <= 1'b0;
                        r_wake_ovf <= 1'b0;
                        r_rr_ptr   <= '0;
                        r_finish   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (w_found) begin
                        // Clear the winner first so a wake to it in
                        // this same cycle re-arms it.
                        r_pending  <= (r_pending & ~w_win_oh) | w_wake;
                        r_grant_id <= w_win;
                        r_rr_ptr   <= w_rr_next;
                        r_dcnt     <= delay_cfg;
                        if (delay_cfg != '0) begin
                            r_state <= S_DELAY;
                        end else begin
                            r_grant <= w_win_oh;
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_stall <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DELAY: begin
                    if (r_dcnt <= DLY_W'(1)) begin
                        r_dcnt  <= '0;
                        r_grant <= f_onehot(r_grant_id);
                        r_state <= S_RUN;
                    end else begin
                        r_dcnt <= r_dcnt - DLY_W'(1);
                    end
                end
                S_RUN: begin
                    if (done) begin
                        r_grant   <= '0;
                        r_act_cnt <= w_cnt_inc;
                        if (w_last) begin
                            r_finish <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_FINISH;
                        end else begin
                            r_state <= S_ARB;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign finish   = r_finish;
    assign stall    = r_stall;
    assign wake_ovf = r_wake_ovf;
    assign act_cnt  = r_act_cnt;

endmodule

// File: tb/tb_proc_token_sched.sv
// tb_proc_token_sched: scenario tasks plus randomized run against a
// transaction-level scheduler model.
module tb_proc_token_sched;

    localparam int NPROC   = 3;
    localparam int DLY_W   = 4;
    localparam int MAX_ACT = 6;
    localparam int CNT_W   = 8;
    localparam int IDW     = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [NPROC-1:0] ext_wake = '0;
    logic [DLY_W-1:0] delay_cfg = '0;
    logic             done = 1'b0;
    logic             wake_tgt_vld = 1'b0;
    logic [IDW-1:0]   wake_tgt = '0;
    logic [NPROC-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             finish;
    logic             stall;
    logic             wake_ovf;
    logic [CNT_W-1:0] act_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: set of pending processes, next-search start, counters.
    bit m_pend[NPROC];
    int m_rr;
    int m_act;
    bit m_ovf;

    proc_token_sched #(
        .NPROC(NPROC), .DLY_W(DLY_W), .MAX_ACT(MAX_ACT),
        .CNT_W(CNT_W), .IDW(IDW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ext_wake(ext_wake), .delay_cfg(delay_cfg),
        .done(done), .wake_tgt_vld(wake_tgt_vld),
        .wake_tgt(wake_tgt), .grant(grant),
        .grant_id(grant_id), .busy(busy), .finish(finish),
        .stall(stall), .wake_ovf(wake_ovf), .act_cnt(act_cnt)
    );

    always #5 clk = ~clk;

    function automatic void m_start();
        for (int i = 0; i < NPROC; i++) m_pend[i] = 1'b0;
        m_pend[0] = 1'b1;
        m_rr  = 0;
        m_act = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void m_wake(int b);
        if (b >= NPROC) begin
            m_ovf = 1'b1;
        end else begin
            if (m_pend[b]) m_ovf = 1'b1;
            m_pend[b] = 1'b1;
        end
    endfunction

    function automatic int m_pick();
        for (int k = 0; k < NPROC; k++) begin
            int idx;
            idx = (m_rr + k) % NPROC;
            if (m_pend[idx]) begin
                m_pend[idx] = 1'b0;
                m_rr = (idx + 1) % NPROC;
                return idx;
            end
        end
        return -1;
    endfunction

    function automatic logic [NPROC-1:0] oh(int id);
        logic [NPROC-1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [NPROC-1:0] ew);
        start = 1'b1;
        ext_wake = ew;
        tick();
        start = 1'b0;
        ext_wake = '0;
    endtask

    // Edges counted from now until grant is seen; 64 means timeout.
    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (grant == '0 && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    task automatic pulse_done(input logic vld, input int tgt,
                              input logic [NPROC-1:0] ew);
        logic [31:0] t;
        t = tgt;
        done = 1'b1;
        wake_tgt_vld = vld;
        wake_tgt = t[IDW-1:0];
        ext_wake = ew;
        tick();
        done = 1'b0;
        wake_tgt_vld = 1'b0;
        ext_wake = '0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({grant, grant_id, busy, finish, stall, wake_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0",
                     {grant, grant_id, busy, finish, stall, wake_ovf});
        end
        n_tests++;
        if (act_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_act_cnt: got %0d want 0", act_cnt);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (busy !== 1'b0 || grant !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: busy %b grant %b want 0 0",
                     busy, grant);
        end
    endtask

    task automatic test_event_chain();
        int wake_tbl[6]  = '{1, 2, 1, 0, 2, -1};
        int order_tbl[6] = '{0, 1, 2, 1, 0, 2};
        int cyc;
        delay_cfg = 4'd1;
        do_start('0);
        n_tests++;
        if (busy !== 1'b1 || grant !== '0) begin
            n_fail++;
            $display("FAIL chain_start: busy %b grant %b want 1 0",
                     busy, grant);
        end
        for (int s = 0; s < 6; s++) begin
            // ARB edge plus one DELAY edge before grant rises.
            wait_grant(cyc);
            n_tests++;
            if (cyc !== 2) begin
                n_fail++;
                $display("FAIL chain_lat[%0d]: got %0d want 2", s, cyc);
            end
            n_tests++;
            if (grant !== oh(order_tbl[s]) ||
                int'(grant_id) !== order_tbl[s]) begin
                n_fail++;
                $display("FAIL chain_grant[%0d]: got %b/%0d want %b/%0d",
                         s, grant, grant_id, oh(order_tbl[s]),
                         order_tbl[s]);
            end
            pulse_done(wake_tbl[s] >= 0, wake_tbl[s] < 0 ? 0 : wake_tbl[s],
                       '0);
            n_tests++;
            if (grant !== '0) begin
                n_fail++;
                $display("FAIL chain_drop[%0d]: got %b want 0", s, grant);
            end
        end
        n_tests++;
        if (act_cnt !== 8'd6 || finish !== 1'b1 || stall !== 1'b0 ||
            busy !== 1'b0) begin
            n_fail++;
            $display("FAIL chain_end: cnt %0d fin %b stall %b busy %b want 6 1 0 0",
                     act_cnt, finish, stall, busy);
        end
    endtask

    task automatic test_deadlock();
        int cyc;
        delay_cfg = 4'd0;
        do_start('0);
        n_tests++;
        if (finish !== 1'b0) begin
            n_fail++;
            $display("FAIL dl_finish_clr: got %b want 0", finish);
        end
        wait_grant(cyc);
        n_tests++;
        if (cyc !== 1 || grant !== 3'b001) begin
            n_fail++;
            $display("FAIL dl_grant: lat %0d grant %b want 1 001", cyc, grant);
        end
        pulse_done(1'b0, 0, '0);
        tick();
        n_tests++;
        if (stall !== 1'b1 || busy !== 1'b0 || finish !== 1'b0 ||
            act_cnt !== 8'd1 || grant !== '0) begin
            n_fail++;
            $display("FAIL dl_stall: stall %b busy %b fin %b cnt %0d want 1 0 0 1",
                     stall, busy, finish, act_cnt);
        end
    endtask

    task automatic test_start_drop();
        int cyc;
        delay_cfg = 4'd0;
        do_start(3'b110);
        wait_grant(cyc);
        n_tests++;
        if (grant !== 3'b001) begin
            n_fail++;
            $display("FAIL sd_grant: got %b want 001", grant);
        end
        pulse_done(1'b0, 0, '0);
        tick();
        n_tests++;
        if (stall !== 1'b1 || wake_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL sd_drop: stall %b ovf %b want 1 0", stall, wake_ovf);
        end
    endtask

    task automatic test_round_robin();
        int order_tbl[3] = '{1, 2, 0};
        int cyc;
        delay_cfg = 4'd0;
        do_start('0);
        wait_grant(cyc);
        ext_wake = 3'b110;
        tick();
        ext_wake = '0;
        pulse_done(1'b1, 0, '0);
        for (int s = 0; s < 3; s++) begin
            wait_grant(cyc);
            n_tests++;
            if (grant !== oh(order_tbl[s]) || cyc !== 1) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got %b lat %0d want %b lat 1",
                         s, grant, cyc, oh(order_tbl[s]));
            end
            pulse_done(1'b0, 0, '0);
        end
        tick();
        n_tests++;
        if (stall !== 1'b1 || act_cnt !== 8'd4 || wake_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_end: stall %b cnt %0d ovf %b want 1 4 0",
                     stall, act_cnt, wake_ovf);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        delay_cfg = 4'd0;
        do_start('0);
        wait_grant(cyc);
        ext_wake = 3'b100;
        tick();
        ext_wake = '0;
        n_tests++;
        if (wake_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_first: got %b want 0", wake_ovf);
        end
        pulse_done(1'b1, 2, 3'b100);
        n_tests++;
        if (wake_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_dup: got %b want 1", wake_ovf);
        end
        wait_grant(cyc);
        n_tests++;
        if (grant !== 3'b100) begin
            n_fail++;
            $display("FAIL ovf_run2: got %b want 100", grant);
        end
        pulse_done(1'b0, 0, '0);
        tick();
        n_tests++;
        if (stall !== 1'b1 || act_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL ovf_once: stall %b cnt %0d want 1 2", stall, act_cnt);
        end
        do_start('0);
        n_tests++;
        if (wake_ovf !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ovf %b stall %b want 0 0", wake_ovf, stall);
        end
        wait_grant(cyc);
        pulse_done(1'b1, 3, '0);
        n_tests++;
        if (wake_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_range: got %b want 1", wake_ovf);
        end
        tick();
        n_tests++;
        if (stall !== 1'b1 || act_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL ovf_range_drop: stall %b cnt %0d want 1 1",
                     stall, act_cnt);
        end
    endtask

    task automatic test_delay();
        int cyc;
        delay_cfg = 4'd5;
        do_start('0);
        tick();
        // Now in DELAY; a new value must not shorten the wait.
        delay_cfg = 4'd1;
        wait_grant(cyc);
        n_tests++;
        if (cyc !== 5 || grant !== 3'b001) begin
            n_fail++;
            $display("FAIL dly5: lat %0d grant %b want 5 001", cyc, grant);
        end
        delay_cfg = 4'd3;
        pulse_done(1'b1, 1, '0);
        wait_grant(cyc);
        n_tests++;
        if (cyc !== 4 || grant !== 3'b010) begin
            n_fail++;
            $display("FAIL dly3: lat %0d grant %b want 4 010", cyc, grant);
        end
        pulse_done(1'b0, 0, '0);
        tick();
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        delay_cfg = 4'd0;
        do_start('0);
        wait_grant(cyc);
        pulse_done(1'b1, 1, 3'b010);
        wait_grant(cyc);
        n_tests++;
        if (grant !== 3'b010 || wake_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_pre: grant %b ovf %b want 010 1", grant, wake_ovf);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({grant, grant_id, busy, finish, stall, wake_ovf} !== '0 ||
            act_cnt !== '0) begin
            n_fail++;
            $display("FAIL rm_async: flags %b cnt %0d want 0 0",
                     {grant, grant_id, busy, finish, stall, wake_ovf}, act_cnt);
        end
        #3 rst_n = 1'b1;
        tick();
        do_start('0);
        wait_grant(cyc);
        n_tests++;
        if (grant !== 3'b001 || cyc !== 1) begin
            n_fail++;
            $display("FAIL rm_restart: grant %b lat %0d want 001 1", grant, cyc);
        end
        pulse_done(1'b0, 0, '0);
        tick();
    endtask

    task automatic test_random();
        int cyc, exp_id, d, hold, tgt;
        logic vld;
        logic [NPROC-1:0] ew;
        for (int it = 0; it < 30; it++) begin
            m_start();
            d = int'($urandom_range(3, 0));
            delay_cfg = DLY_W'(d);
            do_start('0);
            n_tests++;
            if (busy !== 1'b1 || finish !== 1'b0 || wake_ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_start[%0d]: busy %b fin %b ovf %b",
                         it, busy, finish, wake_ovf);
            end
            exp_id = m_pick();
            for (int s = 0; s <= MAX_ACT; s++) begin
                wait_grant(cyc);
                n_tests++;
                if (cyc !== 1 + d || grant !== oh(exp_id) ||
                    int'(grant_id) !== exp_id) begin
                    n_fail++;
                    $display("FAIL rnd_grant[%0d.%0d]: g %b id %0d lat %0d want %b %0d %0d",
                             it, s, grant, grant_id, cyc, oh(exp_id),
                             exp_id, 1 + d);
                end
                hold = int'($urandom_range(2, 0));
                for (int h = 0; h < hold; h++) begin
                    ew = ($urandom_range(2, 0) == 0) ?
                         NPROC'($urandom_range(7, 0)) : '0;
                    for (int b = 0; b < NPROC; b++) if (ew[b]) m_wake(b);
                    ext_wake = ew;
                    tick();
                    ext_wake = '0;
                end
                ew = ($urandom_range(3, 0) == 0) ?
                     NPROC'($urandom_range(7, 0)) : '0;
                vld = ($urandom_range(3, 0) != 0);
                tgt = int'($urandom_range(3, 0));
                for (int b = 0; b < NPROC; b++) if (ew[b]) m_wake(b);
                if (vld) m_wake(tgt);
                m_act++;
                d = int'($urandom_range(3, 0));
                delay_cfg = DLY_W'(d);
                pulse_done(vld, tgt, ew);
                n_tests++;
                if (grant !== '0 || act_cnt !== CNT_W'(m_act) ||
                    wake_ovf !== m_ovf) begin
                    n_fail++;
                    $display("FAIL rnd_done[%0d.%0d]: g %b cnt %0d ovf %b want 0 %0d %b",
                             it, s, grant, act_cnt, wake_ovf, m_act, m_ovf);
                end
                if (m_act == MAX_ACT) begin
                    n_tests++;
                    if (finish !== 1'b1 || busy !== 1'b0 || stall !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd_fin[%0d]: fin %b busy %b stall %b want 1 0 0",
                                 it, finish, busy, stall);
                    end
                    break;
                end
                exp_id = m_pick();
                if (exp_id < 0) begin
                    tick();
                    n_tests++;
                    if (stall !== 1'b1 || busy !== 1'b0 || finish !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rnd_stall[%0d]: stall %b busy %b fin %b want 1 0 0",
                                 it, stall, busy, finish);
                    end
                    break;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_event_chain();
        test_deadlock();
        test_start_drop();
        test_round_robin();
        test_overflow();
        test_delay();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
